wb_xbar_param: RTL

Parametrised Wishbone (classic, single-master) interconnect. It sits between the neorv32 external bus master and NUM_SLAVES peripheral slaves: audio, IO subsystem, SD, and future blocks. It replaces the fixed three-port crossbar with these additions:
- a configurable address map
- registered request and response paths
- bus-error reporting for unmapped addresses
- an optional per-transaction timeout watchdog

---
 rtl/soc_wb_pkg.sv | 28 ++
 rtl/wb_addr_decode.sv | 33 +++
 rtl/wb_xbar_param.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/soc_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_wb_pkg
// Purpose  : Shared Wishbone widths, interconnect FSM encoding and SoC map.
// Revision : 1.0 - initial release
// ============================================================================
package soc_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    // Default SoC address map (audio, IO subsystem, SD card)
    localparam logic [31:0] SOC_AUDIO_BASE = 32'h9000_0000;
    localparam logic [31:0] SOC_AUDIO_MASK = 32'hFF00_0000;
    localparam logic [31:0] SOC_IO_BASE    = 32'h9100_0000;
    localparam logic [31:0] SOC_IO_MASK    = 32'hFF00_0000;
    localparam logic [31:0] SOC_SD_BASE    = 32'h9200_0000;
    localparam logic [31:0] SOC_SD_MASK    = 32'hFF00_0000;

endpackage
`default_nettype wire

// File: rtl/wb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : wb_addr_decode
// Purpose  : Combinational base/mask address decoder, lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module wb_addr_decode
    import soc_wb_pkg::*;
#(
    parameter int                            NUM_SLAVES = 4,
    parameter int                            IDX_W      = 2,
    parameter logic [32*NUM_SLAVES-1:0]      SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]      SLAVE_MASK = {NUM_SLAVES{32'hFFFF_FFFF}}
) (
    input  logic [WB_ADDR_W-1:0] i_adr,
    output logic                 o_hit,
    output logic [IDX_W-1:0]     o_idx
);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((i_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_xbar_param.sv
`default_nettype none
// ============================================================================
// Module   : wb_xbar_param
// Purpose  : Single-master Wishbone interconnect, registered paths, bus error
//            on unmapped access; stall watchdog when WB_XBAR_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module wb_xbar_param
    import soc_wb_pkg::*;
#(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFF}},
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WB_ADDR_W-1:0]          wb_adr,
    input  logic [WB_DATA_W-1:0]          wb_dat_w,
    output logic [WB_DATA_W-1:0]          wb_dat_r,
    input  logic                          wb_we,
    input  logic [WB_SEL_W-1:0]           wb_sel,
    input  logic                          wb_stb,
    input  logic                          wb_cyc,
    output logic                          wb_ack,
    output logic                          wb_err,
    output logic [WB_ADDR_W-1:0]          s_adr,
    output logic [WB_DATA_W-1:0]          s_dat_w,
    output logic                          s_we,
    output logic [WB_SEL_W-1:0]           s_sel,
    output logic [NUM_SLAVES-1:0]         s_stb,
    output logic [NUM_SLAVES-1:0]         s_cyc,
    input  logic [32*NUM_SLAVES-1:0]      s_dat_r,
    input  logic [NUM_SLAVES-1:0]         s_ack,
    input  logic [NUM_SLAVES-1:0]         s_err
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    wb_state_t              r_state, w_next;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_SLAVES-1:0]  r_stb;
    logic [WB_ADDR_W-1:0]   r_adr;
    logic [WB_DATA_W-1:0]   r_dat_w, r_dat_r;
    logic                   r_we, r_ack, r_err;
    logic [WB_SEL_W-1:0]    r_sel;
    logic                   w_req, w_hit, w_sel_ack, w_sel_err, w_expire;
    logic [IDX_W-1:0]       w_idx;

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .i_adr (wb_adr),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    assign w_req     = wb_cyc & wb_stb;
    assign w_sel_ack = s_ack[r_idx];
    assign w_sel_err = s_err[r_idx];

`ifdef WB_XBAR_TIMEOUT_EN
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_cnt;

    // r_cnt holds the number of completed REQ cycles, so the last allowed
    // cycle is the one where it equals TIMEOUT_CYCLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if (r_state == ST_REQ) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign w_expire = (r_state == ST_REQ) && (r_cnt == c_tmo_last);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_expire     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = w_hit ? ST_REQ : ST_RESP;
            ST_REQ: begin
                if (!wb_cyc)                               w_next = ST_IDLE;
                else if (w_sel_err || w_sel_ack || w_expire) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_stb   <= '0;
            r_adr   <= '0;
            r_dat_w <= '0;
            r_dat_r <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_adr   <= wb_adr;
                        r_dat_w <= wb_dat_w;
                        r_we    <= wb_we;
                        r_sel   <= wb_sel;
                        r_idx   <= w_idx;
                        if (w_hit) r_stb <= NUM_SLAVES'(1) << w_idx;
                        else       r_err <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Abort beats everything; slave error beats ack; ack beats expiry.
                    if (!wb_cyc) begin
                        r_stb <= '0;
                    end else if (w_sel_err) begin
                        r_stb <= '0;
                        r_err <= 1'b1;
                    end else if (w_sel_ack) begin
                        r_stb <= '0;
                        r_ack <= 1'b1;
                        if (!r_we) r_dat_r <= s_dat_r[32*r_idx +: 32];
                    end else if (w_expire) begin
                        r_stb <= '0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_adr    = r_adr;
    assign s_dat_w  = r_dat_w;
    assign s_we     = r_we;
    assign s_sel    = r_sel;
    assign s_stb    = r_stb;
    assign s_cyc    = r_stb;
    assign wb_ack   = r_ack;
    assign wb_err   = r_err;
    assign wb_dat_r = r_dat_r;

endmodule
`default_nettype wire
